// File: rtl/button_repeat_filter.sv
// Push-button conditioner: 2-flop synchronizer, CE-timed debounce, and a press pulse with
// optional auto-repeat. BTN_CEO feeds the CE/LOAD input of a downstream counter.
module button_repeat_filter #(
    parameter int DEB_TICKS  = 4,
    parameter int RPT_DELAY  = 500,
    parameter int RPT_PERIOD = 100
) (
    input  logic CLK,
    input  logic RST,
    input  logic CE,
    input  logic BTN_I,
    input  logic REP_EN,
    output logic BTN_O,
    output logic BTN_CEO,
    output logic BTN_REP
);

    localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int RW      = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    localparam logic [7:0]    DEB_TERM    = 8'(DEB_TICKS - 1);
    localparam logic [RW-1:0] DELAY_TERM  = RW'(RPT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_TERM = RW'(RPT_PERIOD - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DELAY  = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;

    logic          sync_meta;
    logic          s;
    logic [7:0]    deb_cnt;
    logic [7:0]    deb_cnt_d;
    logic          btn_d;
    logic [1:0]    state;
    logic [1:0]    state_d;
    logic [RW-1:0] rpt_cnt;
    logic [RW-1:0] rpt_cnt_d;
    logic [RW-1:0] rpt_term;
    logic          ceo_d;
    logic          rise;
    logic          fall;
    logic          rpt_tick;

    // Debounce: any cycle where S agrees with BTN_O restarts the count.
    always_comb begin
        deb_cnt_d = deb_cnt;
        btn_d     = BTN_O;
        if (s == BTN_O) begin
            deb_cnt_d = '0;
        end else if (CE) begin
            if (deb_cnt == DEB_TERM) begin
                btn_d     = ~BTN_O;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt + 8'd1;
            end
        end
    end

    assign rise = btn_d & ~BTN_O;
    assign fall = ~btn_d & BTN_O;

    // Gating with BTN_CEO keeps pulses apart even when CE is held high continuously.
    assign rpt_tick = CE & REP_EN & ~BTN_CEO;
    assign rpt_term = (state == DELAY) ? DELAY_TERM : PERIOD_TERM;

    always_comb begin
        state_d   = state;
        rpt_cnt_d = rpt_cnt;
        ceo_d     = 1'b0;
        if (rise) begin
            state_d   = DELAY;
            rpt_cnt_d = '0;
            ceo_d     = 1'b1;
        end else if (fall) begin
            // Release wins over a coincident terminal count.
            state_d   = IDLE;
            rpt_cnt_d = '0;
        end else begin
            case (state)
                DELAY, REPEAT: begin
                    if (!REP_EN) begin
                        rpt_cnt_d = '0;
                    end else if (rpt_tick) begin
                        if (rpt_cnt == rpt_term) begin
                            rpt_cnt_d = '0;
                            ceo_d     = 1'b1;
                            state_d   = REPEAT;
                        end else begin
                            rpt_cnt_d = rpt_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d   = IDLE;
                    rpt_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_meta <= 1'b0;
            s         <= 1'b0;
            BTN_O     <= 1'b0;
            deb_cnt   <= '0;
            state     <= IDLE;
            rpt_cnt   <= '0;
            BTN_CEO   <= 1'b0;
            BTN_REP   <= 1'b0;
        end else begin
            sync_meta <= BTN_I;
            s         <= sync_meta;
            BTN_O     <= btn_d;
            deb_cnt   <= deb_cnt_d;
            state     <= state_d;
            rpt_cnt   <= rpt_cnt_d;
            BTN_CEO   <= ceo_d;
            BTN_REP   <= (state_d == REPEAT);
        end
    end

endmodule

// File: tb/tb_button_repeat_filter.sv
// Bench for button_repeat_filter: CE every 4 CLK, inputs change once per CE interval,
// outputs compared after every CE edge against a CE-granular behavioural model.
module tb_button_repeat_filter;

    localparam int DEB = 4;
    localparam int DLY = 6;
    localparam int PER = 3;

    logic CLK = 1'b0;
    logic RST, CE, BTN_I, REP_EN;
    logic BTN_O, BTN_CEO, BTN_REP;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state (one update per CE strobe)
    logic hist[$];
    logic m_deb, m_held, m_rep;
    int   m_cnt, m_gap;

    button_repeat_filter #(
        .DEB_TICKS (DEB),
        .RPT_DELAY (DLY),
        .RPT_PERIOD(PER)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .CE     (CE),
        .BTN_I  (BTN_I),
        .REP_EN (REP_EN),
        .BTN_O  (BTN_O),
        .BTN_CEO(BTN_CEO),
        .BTN_REP(BTN_REP)
    );

    always #5 CLK = ~CLK;

    // One CE interval: 4 clocks, optional RST on the first, CE on the last.
    // Returns outputs after the first edge, after the CE edge, the model's expectation,
    // and how many non-CE edges showed BTN_CEO high.
    task automatic step_ce(input logic lvl, input logic ren, input logic rst,
                           output logic [2:0] first, output logic [2:0] obs,
                           output logic [2:0] expv, output int stray);
        logic flip;
        logic ceo;
        stray  = 0;
        BTN_I  = lvl;
        REP_EN = ren;
        for (int c = 0; c < 4; c++) begin
            RST = rst && (c == 0);
            CE  = (c == 3);
            @(posedge CLK);
            #1;
            if (c == 0) first = {BTN_O, BTN_CEO, BTN_REP};
            if (c < 3 && BTN_CEO !== 1'b0) stray++;
        end
        RST = 1'b0;
        CE  = 1'b0;
        obs = {BTN_O, BTN_CEO, BTN_REP};

        if (rst) begin
            hist.delete();
            m_deb  = 1'b0;
            m_held = 1'b0;
            m_rep  = 1'b0;
            m_cnt  = 0;
        end
        hist.push_back(lvl);
        if (hist.size() > 8) void'(hist.pop_front());
        // Accept an edge once the last DEB strobes all saw the opposite level.
        flip = (hist.size() >= DEB);
        for (int j = 0; j < DEB; j++)
            if (hist.size() >= DEB && hist[hist.size() - 1 - j] == m_deb) flip = 1'b0;
        ceo = 1'b0;
        if (flip) begin
            m_deb = ~m_deb;
            m_cnt = 0;
            if (m_deb) begin
                ceo    = 1'b1;
                m_held = 1'b1;
                m_gap  = DLY;
            end else begin
                m_held = 1'b0;
                m_rep  = 1'b0;
            end
        end else if (m_held) begin
            if (!ren) begin
                m_cnt = 0;
            end else begin
                m_cnt++;
                if (m_cnt == m_gap) begin
                    ceo   = 1'b1;
                    m_cnt = 0;
                    m_gap = PER;
                    m_rep = 1'b1;
                end
            end
        end
        expv = {m_deb, ceo, m_rep};
    endtask

    task automatic test_reset();
        logic [2:0] f, o, e;
        int st;
        RST = 1'b1; CE = 1'b1; BTN_I = 1'b1; REP_EN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            n_chk++;
            if ({BTN_O, BTN_CEO, BTN_REP} !== 3'b000)
                $display("FAIL reset[%0d]: o/ceo/rep=%b, want 000", i, {BTN_O, BTN_CEO, BTN_REP});
            else n_pass++;
        end
        RST = 1'b0; CE = 1'b0; BTN_I = 1'b0;
        step_ce(1'b0, 1'b0, 1'b1, f, o, e, st);
        for (int i = 0; i < 4; i++) begin
            step_ce(1'b0, 1'b0, 1'b0, f, o, e, st);
            n_chk++;
            if (o !== e || st != 0 || o !== 3'b000)
                $display("FAIL reset_idle[%0d]: got %b stray=%0d, want %b", i, o, st, e);
            else n_pass++;
        end
    endtask

    task automatic test_clean_press();
        logic [2:0] f, o, e;
        int st, pulses, first_pulse, rep_seen;
        pulses = 0; first_pulse = -1; rep_seen = 0;
        for (int i = 0; i < 46; i++) begin
            step_ce(i < 40, 1'b0, 1'b0, f, o, e, st);
            n_chk++;
            if (o !== e || st != 0)
                $display("FAIL clean[%0d]: got %b stray=%0d, want %b", i, o, st, e);
            else n_pass++;
            if (o[1] === 1'b1) begin
                pulses++;
                if (first_pulse < 0) first_pulse = i;
            end
            if (o[0] !== 1'b0) rep_seen++;
        end
        n_chk++;
        if (pulses != 1) $display("FAIL clean_pulses: got %0d, want 1", pulses);
        else n_pass++;
        n_chk++;
        if (first_pulse != DEB - 1)
            $display("FAIL clean_latency: pulse at CE %0d, want %0d", first_pulse, DEB - 1);
        else n_pass++;
        n_chk++;
        if (rep_seen != 0) $display("FAIL clean_rep: BTN_REP high %0d times, want 0", rep_seen);
        else n_pass++;
    endtask

    task automatic test_bounce();
        logic [2:0] f, o, e;
        int st, h, bad;
        bad = 0;
        for (int r = 0; r < 5; r++) begin
            h = $urandom_range(1, 3);
            for (int i = 0; i < h + 4; i++) begin
                step_ce(i < h, 1'b1, 1'b0, f, o, e, st);
                n_chk++;
                if (o !== e || st != 0)
                    $display("FAIL bounce[%0d.%0d]: got %b stray=%0d, want %b", r, i, o, st, e);
                else n_pass++;
                if (o[2] !== 1'b0 || o[1] !== 1'b0) bad++;
            end
        end
        n_chk++;
        if (bad != 0) $display("FAIL bounce_quiet: %0d CE with BTN_O/BTN_CEO high, want 0", bad);
        else n_pass++;
    endtask

    task automatic test_repeat();
        logic [2:0] f, o, e;
        logic [21:0] got_mask, want_mask;
        int st, rep_bad;
        got_mask = '0; rep_bad = 0;
        want_mask = '0;
        want_mask[3] = 1'b1; want_mask[9] = 1'b1; want_mask[12] = 1'b1;
        want_mask[15] = 1'b1; want_mask[18] = 1'b1; want_mask[21] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step_ce(i < 22, 1'b1, 1'b0, f, o, e, st);
            n_chk++;
            if (o !== e || st != 0)
                $display("FAIL repeat[%0d]: got %b stray=%0d, want %b", i, o, st, e);
            else n_pass++;
            if (i < 22) begin
                got_mask[i] = o[1];
                if (o[0] !== (i >= 9)) rep_bad++;
            end
        end
        n_chk++;
        if (got_mask !== want_mask)
            $display("FAIL repeat_pulses: got %b, want %b", got_mask, want_mask);
        else n_pass++;
        n_chk++;
        if (rep_bad != 0) $display("FAIL repeat_rep: %0d CE with wrong BTN_REP, want 0", rep_bad);
        else n_pass++;
    endtask

    task automatic test_release_on_terminal();
        logic [2:0] f, o, e;
        int st;
        for (int i = 0; i < 20; i++) begin
            step_ce(i < 12, 1'b1, 1'b0, f, o, e, st);
            n_chk++;
            if (o !== e || st != 0)
                $display("FAIL release[%0d]: got %b stray=%0d, want %b", i, o, st, e);
            else n_pass++;
            if (i == 12) begin
                n_chk++;
                if (o !== 3'b111) $display("FAIL release_last_pulse: got %b, want 111", o);
                else n_pass++;
            end
            if (i == 15) begin
                n_chk++;
                if (o !== 3'b000) $display("FAIL release_terminal: got %b, want 000", o);
                else n_pass++;
            end
        end
    endtask

    task automatic test_rep_en_gap();
        logic [2:0] f, o, e;
        int st, quiet;
        quiet = 0;
        for (int i = 0; i < 34; i++) begin
            step_ce(i < 28, !(i >= 13 && i <= 22), 1'b0, f, o, e, st);
            n_chk++;
            if (o !== e || st != 0)
                $display("FAIL rep_en[%0d]: got %b stray=%0d, want %b", i, o, st, e);
            else n_pass++;
            if (i >= 13 && i <= 24 && o[1] !== 1'b0) quiet++;
            if (i == 25) begin
                n_chk++;
                if (o !== 3'b111) $display("FAIL rep_en_resume: got %b, want 111", o);
                else n_pass++;
            end
        end
        n_chk++;
        if (quiet != 0) $display("FAIL rep_en_quiet: %0d pulses, want 0", quiet);
        else n_pass++;
    endtask

    task automatic test_reset_mid_press();
        logic [2:0] f, o, e;
        logic [26:13] got_mask, want_mask;
        int st;
        want_mask = '0;
        want_mask[16] = 1'b1; want_mask[22] = 1'b1; want_mask[25] = 1'b1;
        for (int i = 0; i < 33; i++) begin
            step_ce(i < 27, 1'b1, i == 13, f, o, e, st);
            n_chk++;
            if (o !== e || st != 0)
                $display("FAIL rst_mid[%0d]: got %b stray=%0d, want %b", i, o, st, e);
            else n_pass++;
            if (i == 13) begin
                n_chk++;
                if (f !== 3'b000) $display("FAIL rst_mid_clear: got %b, want 000", f);
                else n_pass++;
            end
            if (i >= 13 && i <= 26) got_mask[i] = o[1];
        end
        n_chk++;
        if (got_mask !== want_mask)
            $display("FAIL rst_mid_pulses: got %b, want %b", got_mask, want_mask);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [2:0] f, o, e;
        logic lvl, ren, rst;
        int st, left;
        lvl = 1'b0; ren = 1'b1; left = 0;
        for (int i = 0; i < 300; i++) begin
            if (left == 0) begin
                lvl  = ~lvl;
                left = $urandom_range(1, 16);
            end
            left--;
            if ($urandom_range(0, 9) == 0) ren = ~ren;
            rst = ($urandom_range(0, 79) == 0);
            step_ce(lvl, ren, rst, f, o, e, st);
            n_chk++;
            if (o !== e || st != 0)
                $display("FAIL random[%0d]: got %b stray=%0d, want %b", i, o, st, e);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_repeat();
        test_release_on_terminal();
        test_rep_en_gap();
        test_reset_mid_press();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/button_repeat_filter.md
BUTTON_REPEAT_FILTER -- requirements
Module: button_repeat_filter

Interface
REQ-001 Parameter DEB_TICKS, default 4: number of consecutive CE strobes of stable opposite level needed to accept a button edge (range 1..255).
REQ-002 Parameter RPT_DELAY, default 500: CE strobes from accepted press to first auto-repeat pulse (range 1..65535).
REQ-003 Parameter RPT_PERIOD, default 100: CE strobes between subsequent auto-repeat pulses (range 1..65535).
REQ-004 CLK  input  1  single system clock; all state is updated on its rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 CE  input  1  one-CLK-wide timebase strobe from the frequency divider (1 kHz nominal).
REQ-007 BTN_I  input  1  raw asynchronous button level, 1 = pressed.
REQ-008 REP_EN  input  1  auto-repeat enable, 1 = repeat pulses generated while held.
REQ-009 BTN_O  output  1  debounced button level.
REQ-010 BTN_CEO  output  1  one-CLK pulse per accepted press and per auto-repeat event; drives the CE/LOAD input of the downstream counter.
REQ-011 BTN_REP  output  1  high while the block is in the REPEAT state.

Function
REQ-012 BTN_I SHALL pass through a 2-flop synchronizer clocked by CLK before any other use; the second flop output is called S.
REQ-013 The debounce counter SHALL clear in any cycle where S equals BTN_O.
REQ-014 The debounce counter SHALL increment on CE only while S differs from BTN_O.
REQ-015 When CE is high, S differs from BTN_O and the debounce counter equals DEB_TICKS-1, BTN_O SHALL toggle on that edge and the counter SHALL clear.
REQ-016 A glitch shorter than DEB_TICKS CE strobes SHALL NOT change BTN_O.
REQ-017 FSM states SHALL be IDLE, DELAY and REPEAT, with one repeat counter sized for max(RPT_DELAY, RPT_PERIOD)-1.
REQ-018 IDLE: when BTN_O rises, the FSM SHALL go to DELAY, clear the repeat counter, and assert BTN_CEO in the same cycle in which BTN_O first reads 1.
REQ-019 DELAY: on each CE with REP_EN=1, the repeat counter SHALL increment.
REQ-020 DELAY: on CE with the counter at RPT_DELAY-1, the FSM SHALL pulse BTN_CEO, go to REPEAT and clear the counter.
REQ-021 REPEAT: on each CE with REP_EN=1, the repeat counter SHALL increment.
REQ-022 REPEAT: on CE with the counter at RPT_PERIOD-1, the FSM SHALL pulse BTN_CEO and clear the counter; the counter wraps and never exceeds its terminal value.
REQ-023 In DELAY or REPEAT with REP_EN=0, the repeat counter SHALL be held at 0, no repeat pulses SHALL occur, and the state SHALL be kept; counting restarts from 0 when REP_EN returns to 1.
REQ-024 When BTN_O falls in DELAY or REPEAT, the FSM SHALL go to IDLE, clear the counter, and produce no BTN_CEO pulse.
REQ-025 Release takes priority: if a release and a repeat terminal count occur in the same cycle, no pulse SHALL be issued.
REQ-026 A BTN_O rise in any state other than IDLE is impossible by construction; if one occurs, the FSM SHALL treat it as IDLE.
REQ-027 BTN_CEO SHALL never be high for two consecutive CLK cycles.
REQ-028 BTN_REP SHALL be a registered decode of state == REPEAT.
REQ-029 Press-to-pulse latency SHALL be 2 CLK (synchronizer) plus DEB_TICKS CE strobes, with the pulse coincident with the BTN_O rise.

Reset
REQ-030 With RST high at a CLK edge, the synchronizer flops, BTN_O, BTN_CEO, BTN_REP and both counters SHALL be 0 and the state SHALL be IDLE, regardless of CE.
REQ-031 Reset asserted mid-press SHALL abort DELAY/REPEAT with no pulse.
REQ-032 If BTN_I is still held when reset is released, the press SHALL be re-accepted only after a full debounce, followed by one BTN_CEO pulse.
REQ-033 The block SHALL NOT synchronize RST internally; it consumes the already-synchronized reset.

Verification
Bench setup: DEB_TICKS=4, RPT_DELAY=6, RPT_PERIOD=3, CE every 4 CLK.
REQ-034 Clean press held for 40 CE with REP_EN=0 -> BTN_O rises at CE #4 after the sync delay; exactly one BTN_CEO pulse; BTN_REP stays 0.
REQ-035 Bounce of 1-3 CE high then low, repeated 5 times -> BTN_O stays 0 and BTN_CEO stays 0 throughout.
REQ-036 Press held 18 CE after acceptance with REP_EN=1 -> pulses at acceptance, +6 CE, +9, +12, +15 and +18 CE (6 total); BTN_REP is high from the +6 pulse onward.
REQ-037 Release timed so that the BTN_O fall coincides with a repeat terminal count -> no pulse in that cycle; FSM in IDLE; BTN_REP is 0 on the next cycle.
REQ-038 REP_EN dropped for 10 CE in REPEAT, then raised -> no pulses while low; the next pulse arrives 3 CE after REP_EN rises.
REQ-039 RST pulsed for 1 CLK during REPEAT with the button held -> all outputs 0 the next cycle; one new pulse after 4 CE; the repeat sequence restarts with a 6 CE delay.
